// File: rtl/sram_request_sequencer_pkg.sv
// Shared definitions for the SRAM request sequencer: state encodings, default widths
// and default cycle counts.
package sram_request_sequencer_pkg;

    localparam int unsigned DEF_ADDR_W         = 11;
    localparam int unsigned DEF_DATA_W         = 8;
    localparam int unsigned DEF_FIFO_DEPTH     = 4;
    localparam int unsigned DEF_ACCESS_CYCLES  = 5;
    localparam int unsigned DEF_RECOVER_CYCLES = 1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccess  = 2'd1,
        StRecover = 2'd2
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_request_sequencer_fifo.sv
// Synchronous request FIFO. Pointers carry one extra wrap bit so full/empty come
// straight from a pointer compare.
module sram_req_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // A full cycle accepts nothing, even when a pop happens on the same edge.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout    = mem_q[rptr_q[AW-1:0]];

    // Pointer registers, cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sram_request_sequencer.sv
// Request sequencer in front of the SRAM controller: queues host requests, holds each
// access strobe for a fixed window, captures read data on latch and returns one response
// per request in order.
module sram_request_sequencer
    import sram_request_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int unsigned ACCESS_CYCLES  = DEF_ACCESS_CYCLES,
    parameter int unsigned RECOVER_CYCLES = DEF_RECOVER_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              ctrl_read,
    output logic              ctrl_write,
    input  logic              ctrl_latch,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy
);

    localparam int unsigned FW    = 1 + ADDR_W + DATA_W;
    localparam int unsigned CNT_W = $clog2(max_u(ACCESS_CYCLES, RECOVER_CYCLES) + 1);

    logic          fifo_full, fifo_empty, fifo_pop;
    logic [FW-1:0] fifo_dout;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_write_q, op_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic              got_latch_q, got_latch_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              latch_hit;

    sram_req_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_valid),
        .pop   (fifo_pop),
        .din   ({req_write, req_addr, req_wdata}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign req_ready   = ~fifo_full;
    assign busy        = (state_q != StIdle) | ~fifo_empty;
    assign ctrl_read   = rd_q;
    assign ctrl_write  = wr_q;
    assign sram_addr   = addr_q;
    assign sram_wdata  = wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_rdata   = rsp_rdata_q;

    // First latch pulse of a read access only; later pulses are ignored.
    assign latch_hit = (state_q == StAccess) & ~op_write_q & ~got_latch_q & ctrl_latch;

    // Next-state, strobe and response logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_write_d    = op_write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        got_latch_d   = got_latch_q;
        cap_d         = cap_q;
        rsp_rdata_d   = rsp_rdata_q;
        rd_d          = 1'b0;
        wr_d          = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        fifo_pop      = 1'b0;

        if (latch_hit) begin
            got_latch_d = 1'b1;
            cap_d       = sram_rdata;
        end

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    op_write_d  = fifo_dout[FW-1];
                    addr_d      = fifo_dout[FW-2:DATA_W];
                    wdata_d     = fifo_dout[DATA_W-1:0];
                    got_latch_d = 1'b0;
                    cnt_d       = CNT_W'(ACCESS_CYCLES - 1);
                    rd_d        = ~fifo_dout[FW-1];
                    wr_d        = fifo_dout[FW-1];
                    state_d     = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    // A latch on the final access cycle still counts for this response.
                    state_d       = StRecover;
                    cnt_d         = CNT_W'(RECOVER_CYCLES - 1);
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = ~op_write_q & ~(got_latch_q | latch_hit);
                    if (~op_write_q & (got_latch_q | latch_hit)) begin
                        rsp_rdata_d = latch_hit ? sram_rdata : cap_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    rd_d  = ~op_write_q;
                    wr_d  = op_write_q;
                end
            end
            StRecover: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, access registers and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            op_write_q    <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            got_latch_q   <= 1'b0;
            cap_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_write_q    <= op_write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            got_latch_q   <= got_latch_d;
            cap_q         <= cap_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_request_sequencer.sv
// Directed bench for sram_request_sequencer with default parameters.
module tb_sram_request_sequencer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [10:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic        ctrl_read;
    logic        ctrl_write;
    logic        ctrl_latch;
    logic [10:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic [7:0]  sram_rdata;
    logic        busy;

    int nvec;
    int nbad;

    sram_request_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .ctrl_read   (ctrl_read),
        .ctrl_write  (ctrl_write),
        .ctrl_latch  (ctrl_latch),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One request from idle; observes 11 cycles and returns what it saw.
    // Cycle c is the c-th falling edge after the request was driven.
    task automatic run_single(input logic wr, input logic [10:0] addr, input logic [7:0] wd,
                              input int latch_c, input logic [7:0] ld,
                              output int rd_n, output int wr_n, output int first_c,
                              output int rsp_n, output int rsp_c, output logic [7:0] rsp_d,
                              output logic rsp_to, output int both_n, output int bus_bad);
        rd_n = 0; wr_n = 0; first_c = 0; rsp_n = 0; rsp_c = 0;
        rsp_d = '0; rsp_to = 1'b0; both_n = 0; bus_bad = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (ctrl_read) rd_n++;
            if (ctrl_write) wr_n++;
            if (ctrl_read && ctrl_write) both_n++;
            if ((ctrl_read || ctrl_write) && first_c == 0) first_c = c;
            if ((ctrl_read || ctrl_write) && (sram_addr !== addr || (wr && sram_wdata !== wd)))
                bus_bad++;
            if (rsp_valid) begin
                rsp_n++; rsp_c = c; rsp_d = rsp_rdata; rsp_to = rsp_timeout;
            end
            ctrl_latch = (latch_c != 0) && (c == latch_c || c == latch_c + 1);
            if (latch_c != 0 && c == latch_c) sram_rdata = ld;
            else if (latch_c != 0 && c == latch_c + 1) sram_rdata = ~ld;
            else sram_rdata = 8'h00;
        end
        ctrl_latch = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++;
        if ({ctrl_read, ctrl_write, rsp_valid, rsp_timeout, busy} !== 5'b0) begin
            nbad++; $display("FAIL reset_ctrl: got %b expected 00000",
                             {ctrl_read, ctrl_write, rsp_valid, rsp_timeout, busy});
        end
        nvec++;
        if ({sram_addr, sram_wdata, rsp_rdata} !== 27'h0) begin
            nbad++; $display("FAIL reset_data: got %h expected 0",
                             {sram_addr, sram_wdata, rsp_rdata});
        end
        nvec++;
        if (req_ready !== 1'b1) begin
            nbad++; $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        nvec++;
        if ({busy, req_ready, ctrl_read, ctrl_write, rsp_valid} !== 5'b01000) begin
            nbad++; $display("FAIL release_idle: got %b expected 01000",
                             {busy, req_ready, ctrl_read, ctrl_write, rsp_valid});
        end
    endtask

    task automatic test_read();
        int rd_n, wr_n, first_c, rsp_n, rsp_c, both_n, bus_bad;
        logic [7:0] rsp_d;
        logic rsp_to;
        // Latch in the 3rd access cycle with 0xA5; a second pulse carries 0x5A and must be ignored.
        run_single(1'b0, 11'h005, 8'h00, 4, 8'hA5,
                   rd_n, wr_n, first_c, rsp_n, rsp_c, rsp_d, rsp_to, both_n, bus_bad);
        nvec++;
        if (rd_n !== 5 || wr_n !== 0) begin
            nbad++; $display("FAIL read_strobes: got rd=%0d wr=%0d expected rd=5 wr=0", rd_n, wr_n);
        end
        nvec++;
        if (first_c !== 2) begin
            nbad++; $display("FAIL read_latency: got cycle %0d expected 2", first_c);
        end
        nvec++;
        if (bus_bad !== 0) begin
            nbad++; $display("FAIL read_addr: got %0d bad cycles expected 0", bus_bad);
        end
        nvec++;
        if (rsp_n !== 1 || rsp_c !== 7) begin
            nbad++; $display("FAIL read_rsp: got n=%0d at %0d expected n=1 at 7", rsp_n, rsp_c);
        end
        nvec++;
        if (rsp_d !== 8'hA5 || rsp_to !== 1'b0) begin
            nbad++; $display("FAIL read_data: got %h/%b expected a5/0", rsp_d, rsp_to);
        end
    endtask

    task automatic test_write();
        int rd_n, wr_n, first_c, rsp_n, rsp_c, both_n, bus_bad;
        logic [7:0] rsp_d;
        logic rsp_to;
        run_single(1'b1, 11'h010, 8'h3C, 0, 8'h00,
                   rd_n, wr_n, first_c, rsp_n, rsp_c, rsp_d, rsp_to, both_n, bus_bad);
        nvec++;
        if (wr_n !== 5 || rd_n !== 0) begin
            nbad++; $display("FAIL write_strobes: got rd=%0d wr=%0d expected rd=0 wr=5", rd_n, wr_n);
        end
        nvec++;
        if (bus_bad !== 0) begin
            nbad++; $display("FAIL write_bus: got %0d bad cycles expected 0", bus_bad);
        end
        nvec++;
        if (rsp_n !== 1 || rsp_c !== 7 || rsp_to !== 1'b0) begin
            nbad++; $display("FAIL write_rsp: got n=%0d at %0d to=%b expected n=1 at 7 to=0",
                             rsp_n, rsp_c, rsp_to);
        end
        // Writes leave the previous read data in place.
        nvec++;
        if (rsp_d !== 8'hA5) begin
            nbad++; $display("FAIL write_rdata_hold: got %h expected a5", rsp_d);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] addrs [6];
        logic [7:0]  exp_d [6];
        int pi, ri, stall_n, stall_first, accept5, both_n, gap, min_gap, windows, rsp_bad;
        logic prev_strobe;
        for (int i = 0; i < 6; i++) addrs[i] = 11'h100 + 11'(i * 3);
        // Reads return addr low byte ^ 0x80; writes echo the previous read's data.
        exp_d[0] = 8'h80; exp_d[1] = 8'h80; exp_d[2] = 8'h86;
        exp_d[3] = 8'h86; exp_d[4] = 8'h8C; exp_d[5] = 8'h8C;
        pi = 0; ri = 0; stall_n = 0; stall_first = -1; accept5 = -1; both_n = 0;
        gap = 0; min_gap = 1000; windows = 0; rsp_bad = 0; prev_strobe = 1'b0;
        for (int t = 0; t < 150 && !(ri == 6 && !busy); t++) begin
            @(negedge clk);
            if (ctrl_read && ctrl_write) both_n++;
            if (ctrl_read || ctrl_write) begin
                if (!prev_strobe) begin
                    windows++;
                    if (windows > 1 && gap < min_gap) min_gap = gap;
                end
                gap = 0;
            end else begin
                gap++;
            end
            prev_strobe = ctrl_read | ctrl_write;
            if (rsp_valid) begin
                if (ri >= 6 || rsp_rdata !== exp_d[ri] || rsp_timeout !== 1'b0) begin
                    rsp_bad++;
                    $display("FAIL b2b_rsp%0d: got %h/%b expected %h/0", ri, rsp_rdata,
                             rsp_timeout, (ri < 6) ? exp_d[ri] : 8'hxx);
                end
                ri++;
            end
            ctrl_latch = ctrl_read;
            sram_rdata = sram_addr[7:0] ^ 8'h80;
            if (pi < 6) begin
                req_valid = 1'b1; req_write = 1'(pi % 2); req_addr = addrs[pi];
                req_wdata = 8'(pi);
                if (req_ready) begin
                    if (pi == 5) accept5 = t;
                    pi++;
                end else begin
                    if (stall_first < 0) stall_first = t;
                    stall_n++;
                end
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0; ctrl_latch = 1'b0;
        nvec++;
        if (stall_first !== 5 || stall_n !== 4 || accept5 !== 9) begin
            nbad++; $display("FAIL b2b_full: got stall@%0d n=%0d accept@%0d expected 5/4/9",
                             stall_first, stall_n, accept5);
        end
        nvec++;
        if (windows !== 6 || min_gap !== 2) begin
            nbad++; $display("FAIL b2b_windows: got %0d windows gap %0d expected 6 gap 2",
                             windows, min_gap);
        end
        nvec++;
        if (both_n !== 0) begin
            nbad++; $display("FAIL b2b_both: got %0d cycles expected 0", both_n);
        end
        nvec++;
        if (ri !== 6 || rsp_bad !== 0) begin
            nbad++; $display("FAIL b2b_order: got %0d rsp %0d bad expected 6 rsp 0 bad", ri, rsp_bad);
        end
        nvec++;
        if (busy !== 1'b0) begin
            nbad++; $display("FAIL b2b_drain: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_timeout();
        int rd_n, wr_n, first_c, rsp_n, rsp_c, both_n, bus_bad;
        logic [7:0] rsp_d;
        logic rsp_to;
        run_single(1'b0, 11'h020, 8'h00, 0, 8'h00,
                   rd_n, wr_n, first_c, rsp_n, rsp_c, rsp_d, rsp_to, both_n, bus_bad);
        nvec++;
        if (rsp_n !== 1 || rsp_c !== 7 || rsp_to !== 1'b1) begin
            nbad++; $display("FAIL timeout_rsp: got n=%0d at %0d to=%b expected n=1 at 7 to=1",
                             rsp_n, rsp_c, rsp_to);
        end
        // Latch on the very first access cycle.
        run_single(1'b0, 11'h021, 8'h00, 2, 8'h77,
                   rd_n, wr_n, first_c, rsp_n, rsp_c, rsp_d, rsp_to, both_n, bus_bad);
        nvec++;
        if (rsp_n !== 1 || rsp_to !== 1'b0 || rsp_d !== 8'h77 || rd_n !== 5) begin
            nbad++; $display("FAIL after_timeout: got n=%0d to=%b d=%h rd=%0d expected 1/0/77/5",
                             rsp_n, rsp_to, rsp_d, rd_n);
        end
    endtask

    task automatic test_reset_mid_access();
        int rsp_pre, rsp_post, strobe_post;
        logic strobe_before;
        rsp_pre = 0; rsp_post = 0; strobe_post = 0;
        // r0 pushed at edge 1 and popped at edge 2; r1..r4 queue behind it.
        // r1 is popped at edge 9, so falling edge 10 sits in its 2nd access cycle.
        for (int t = 0; t <= 10; t++) begin
            @(negedge clk);
            if (rsp_valid) rsp_pre++;
            if (t <= 4) begin
                req_valid = 1'b1; req_write = t[0]; req_addr = 11'h200 + 11'(t);
                req_wdata = 8'(t);
            end else begin
                req_valid = 1'b0;
            end
        end
        strobe_before = ctrl_read | ctrl_write;
        reset = 1'b0;
        #1;
        nvec++;
        if (strobe_before !== 1'b1 || rsp_pre !== 1) begin
            nbad++; $display("FAIL pre_reset: got strobe=%b rsp=%0d expected 1/1",
                             strobe_before, rsp_pre);
        end
        nvec++;
        if ({ctrl_read, ctrl_write, busy, req_ready} !== 4'b0001) begin
            nbad++; $display("FAIL reset_async: got %b expected 0001",
                             {ctrl_read, ctrl_write, busy, req_ready});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (rsp_valid) rsp_post++;
            if (ctrl_read || ctrl_write) strobe_post++;
        end
        nvec++;
        if (rsp_post !== 0 || strobe_post !== 0) begin
            nbad++; $display("FAIL reset_lost: got rsp=%0d strobe=%0d expected 0/0",
                             rsp_post, strobe_post);
        end
        nvec++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            nbad++; $display("FAIL reset_after: got busy=%b ready=%b expected 0/1",
                             busy, req_ready);
        end
    endtask

    initial begin
        nvec = 0; nbad = 0;
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        ctrl_latch = 1'b0; sram_rdata = '0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
